atm_dispenser: RTL and testbench

ATM_DISPENSER -- requirements
Module: atm_dispenser

---
 rtl/atm_pkg.sv | 22 ++
 rtl/atm_dispenser.sv | 146 ++++++++++++++
 tb/tb_atm_dispenser.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// Shared types and constants for the note dispenser.
// State encoding, error codes and parameter defaults.
package atm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    DISPENSE,
    WAIT_SENSE,
    DONE,
    ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_AMOUNT = 2'd1;
  localparam logic [1:0] ERR_FUNDS  = 2'd2;
  localparam logic [1:0] ERR_JAM    = 2'd3;

  localparam int NOTE_VALUE_DEF = 20;
  localparam int MAX_NOTES_DEF  = 25;

endpackage

// File: rtl/atm_dispenser.sv
// Cash dispenser: validates a withdrawal, then ejects notes one by one.
// Define ATM_DISP_TIMEOUT_EN to abort when the exit sensor stays silent.
module atm_dispenser
  import atm_pkg::*;
#(
  parameter int NOTE_VALUE  = NOTE_VALUE_DEF,
  parameter int AMT_W       = 10,
  parameter int BAL_W       = 16,
  parameter int MAX_NOTES   = MAX_NOTES_DEF,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [AMT_W-1:0] req_amount,
  input  logic [BAL_W-1:0] balance,
  output logic             note_pulse,
  input  logic             note_sensed,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [5:0]       notes_out
);

  localparam int W = (AMT_W > BAL_W) ? AMT_W : BAL_W;

  state_e           state_q, state_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [BAL_W-1:0] bal_q, bal_d;
  logic [5:0]       rem_q, rem_d;
  logic [5:0]       notes_q, notes_d;
  logic [1:0]       code_q, code_d;

  logic [AMT_W-1:0] quo, rmd;
  logic [W-1:0]     amt_x, bal_x;
  logic             bad_amt;

  assign quo     = amt_q / AMT_W'(NOTE_VALUE);
  assign rmd     = amt_q % AMT_W'(NOTE_VALUE);
  assign amt_x   = W'(amt_q);
  assign bal_x   = W'(bal_q);
  assign bad_amt = (amt_q == '0) || (rmd != '0) ||
                   (quo > AMT_W'(MAX_NOTES));

`ifdef ATM_DISP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      amt_q   <= '0;
      bal_q   <= '0;
      rem_q   <= '0;
      notes_q <= '0;
      code_q  <= ERR_NONE;
`ifdef ATM_DISP_TIMEOUT_EN
      to_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      amt_q   <= amt_d;
      bal_q   <= bal_d;
      rem_q   <= rem_d;
      notes_q <= notes_d;
      code_q  <= code_d;
`ifdef ATM_DISP_TIMEOUT_EN
      to_q    <= to_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    amt_d   = amt_q;
    bal_d   = bal_q;
    rem_d   = rem_q;
    notes_d = notes_q;
    code_d  = code_q;
`ifdef ATM_DISP_TIMEOUT_EN
    to_d    = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          amt_d   = req_amount;
          bal_d   = balance;
          notes_d = '0;
          code_d  = ERR_NONE;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (bad_amt) begin
          code_d  = ERR_AMOUNT;
          state_d = ERROR;
        end else if (amt_x > bal_x) begin
          code_d  = ERR_FUNDS;
          state_d = ERROR;
        end else begin
          rem_d   = 6'(quo);
          state_d = DISPENSE;
        end
      end
      DISPENSE: begin
`ifdef ATM_DISP_TIMEOUT_EN
        to_d    = '0;
`endif
        state_d = WAIT_SENSE;
      end
      WAIT_SENSE: begin
        if (note_sensed) begin
          notes_d = notes_q + 6'd1;
          rem_d   = rem_q - 6'd1;
          state_d = (rem_q == 6'd1) ? DONE : DISPENSE;
        end
`ifdef ATM_DISP_TIMEOUT_EN
        else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
          code_d  = ERR_JAM;
          state_d = ERROR;
        end else begin
          to_d = to_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign note_pulse = (state_q == DISPENSE);
  assign done       = (state_q == DONE);
  assign err        = (state_q == ERROR);
  assign err_code   = code_q;
  assign notes_out  = notes_q;

endmodule

// File: tb/tb_atm_dispenser.sv
// Scoreboard bench for atm_dispenser: directed requests, exit-sensor model,
// and a monitor that checks every done/err pulse against the queue.
module tb_atm_dispenser;
  import atm_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [9:0] req_amount;
  logic [15:0] balance;
  logic       note_pulse;
  logic       note_sensed;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [5:0] notes_out;

  logic model_sense;
  logic stray_sense;
  assign note_sensed = model_sense | stray_sense;

  atm_dispenser #(
    .NOTE_VALUE (20),
    .AMT_W      (10),
    .BAL_W      (16),
    .MAX_NOTES  (25),
    .TIMEOUT_CYC(10)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_amount (req_amount),
    .balance    (balance),
    .note_pulse (note_pulse),
    .note_sensed(note_sensed),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .notes_out  (notes_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       is_err;
    int       code;
    int       notes;
    int       pulses;
    int       lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc = 0;
  int acc_cyc = 0;
  int pulse_total = 0;
  int pulse_base = 0;
  int sense_cnt = 0;
  int sense_limit = 0;

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  always @(posedge clk) begin
    if (!reset && req_valid && req_ready) begin
      acc++;
      acc_cyc = cyc;
      pulse_base = pulse_total;
    end
    cyc++;
  end

  always @(negedge clk)
    if (note_pulse) pulse_total++;

  // Monitor: every done/err pulse must match the oldest expectation
  always @(negedge clk) begin
    if (!reset && (done || err)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("err_flag", int'(err), int'(e.is_err));
        check("done_flag", int'(done), int'(!e.is_err));
        check("err_code", int'(err_code), e.code);
        check("notes_out", int'(notes_out), e.notes);
        check("pulses", pulse_total - pulse_base, e.pulses);
        if (e.lat >= 0) check("latency", cyc - acc_cyc, e.lat);
      end
    end
  end

  // Exit sensor: reports each note three cycles after its pulse
  initial begin
    model_sense = 1'b0;
    @(negedge clk);
    forever begin
      if (note_pulse && sense_cnt < sense_limit) begin
        sense_cnt++;
        repeat (3) @(negedge clk);
        model_sense = 1'b1;
        @(negedge clk);
        model_sense = 1'b0;
      end else begin
        @(negedge clk);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (busy) check("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic issue(input int amt, input int bal,
                       input exp_t e, input int nsense);
    sense_limit = sense_cnt + nsense;
    wait_ready();
    sb.push_back(e);
    req_valid  = 1'b1;
    req_amount = 10'(amt);
    balance    = 16'(bal);
    @(negedge clk);
    req_valid = 1'b0;
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int a0;
    int p0;
    int k;
    int n;
    reset       = 1'b1;
    req_valid   = 1'b0;
    req_amount  = '0;
    balance     = '0;
    stray_sense = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_pulse", int'(note_pulse), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_code", int'(err_code), 0);
    check("rst_notes", int'(notes_out), 0);
    @(negedge clk);

    issue(60, 100, '{1'b0, 0, 3, 3, -1}, 3);
    issue(50, 100, '{1'b1, 1, 0, 0, 2}, 0);
    issue(200, 180, '{1'b1, 2, 0, 0, 2}, 0);
    issue(520, 100, '{1'b1, 1, 0, 0, 2}, 0);
    issue(0, 100, '{1'b1, 1, 0, 0, 2}, 0);
    issue(20, 20, '{1'b0, 0, 1, 1, 6}, 1);
    issue(500, 500, '{1'b0, 0, 25, 25, -1}, 25);
    issue(40, 19, '{1'b1, 2, 0, 0, 2}, 0);

    // Request held valid while busy, with different values offered
    sense_limit = sense_cnt + 3;
    wait_ready();
    sb.push_back('{1'b0, 0, 3, 3, -1});
    a0 = acc;
    req_valid  = 1'b1;
    req_amount = 10'd60;
    balance    = 16'd100;
    @(negedge clk);
    req_amount = 10'd40;
    balance    = 16'd10;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    if (!done) check("busy_done_timeout", 0, 1);
    check("busy_accepts", acc - a0, 1);
    wait_idle();

    p0 = pulse_total;
    stray_sense = 1'b1;
    repeat (3) @(negedge clk);
    stray_sense = 1'b0;
    @(negedge clk);
    check("stray_notes", int'(notes_out), 3);
    check("stray_busy", int'(busy), 0);
    check("stray_pulses", pulse_total - p0, 0);

`ifdef ATM_DISP_TIMEOUT_EN
    issue(40, 100, '{1'b1, 3, 1, 2, -1}, 1);
`endif

    // Reset during the second WAIT_SENSE of an 80 request
    sense_limit = sense_cnt + 10;
    wait_ready();
    req_valid  = 1'b1;
    req_amount = 10'd80;
    balance    = 16'd100;
    @(negedge clk);
    req_valid = 1'b0;
    k = 0;
    n = 0;
    while (k < 2 && n < 200) begin
      @(negedge clk);
      if (note_pulse) k++;
      n++;
    end
    check("mid_pulses_seen", k, 2);
    @(negedge clk);
    check("mid_in_wait", int'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sense_limit = sense_cnt;
    check("mid_ready", int'(req_ready), 1);
    check("mid_busy", int'(busy), 0);
    check("mid_pulse", int'(note_pulse), 0);
    check("mid_done", int'(done), 0);
    check("mid_err", int'(err), 0);
    check("mid_code", int'(err_code), 0);
    check("mid_notes", int'(notes_out), 0);
    repeat (8) @(negedge clk);

    check("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
